// File: rtl/ifft_sym_sched.sv
// Symbol-level scheduler for the SC-FDMA RX 3/6/12-point IFFT: drops DMRS symbols,
// starts the IFFT per data symbol, guards it with a watchdog and hands results downstream.
module ifft_sym_sched #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned SYM_PER_SLOT = 7,
  parameter int unsigned DMRS_SYM     = 3,
  parameter int unsigned TIMEOUT      = 64
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_cfg_load,
  input  logic [1:0] i_cfg_n_sc,
  input  logic       i_abort,
  input  logic       i_sym_valid,
  output logic       o_sym_ready,
  output logic       o_sym_ack,
  output logic       o_ifft_start,
  output logic [1:0] o_ifft_n_sc,
  input  logic       i_ifft_done,
  output logic       o_out_valid,
  input  logic       i_out_ready,
  output logic [2:0] o_out_sym_idx,
  output logic       o_out_last,
  output logic       o_dmrs_skip,
  output logic       o_cfg_err,
  output logic       o_err_timeout,
  output logic       o_busy
);

  localparam int unsigned WD_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [2:0]  LAST_IDX = 3'(SYM_PER_SLOT - 1);
  localparam logic [2:0]  DMRS_IDX = 3'(DMRS_SYM);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_SYM,
    S_START,
    S_RUN,
    S_SKIP,
    S_HOLD,
    S_ERR
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic [1:0]      n_sc_q, n_sc_d;
  logic            cfg_err_q, cfg_err_d;
  logic            hold_first_q, hold_first_d;

  function automatic logic [2:0] cnt_inc(input logic [2:0] c);
    return (c == LAST_IDX) ? 3'd0 : c + 3'd1;
  endfunction

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    state_d      = state_q;
    cnt_d        = cnt_q;
    wd_d         = wd_q;
    n_sc_d       = n_sc_q;
    cfg_err_d    = 1'b0;
    hold_first_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (i_cfg_load) begin
          if (i_cfg_n_sc == 2'd3) begin
            cfg_err_d = 1'b1;
          end else begin
            n_sc_d  = i_cfg_n_sc;
            cnt_d   = 3'd0;
            state_d = S_WAIT_SYM;
          end
        end
      end
      S_WAIT_SYM: begin
        if (i_sym_valid) state_d = (cnt_q == DMRS_IDX) ? S_SKIP : S_START;
      end
      S_SKIP: begin
        cnt_d   = cnt_inc(cnt_q);
        state_d = S_WAIT_SYM;
      end
      S_START: begin
        wd_d    = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        // A done on the expiry cycle still completes the symbol.
        if (i_ifft_done) begin
          state_d      = S_HOLD;
          hold_first_d = 1'b1;
        end else if (wd_q == WD_MAX) begin
          state_d = S_ERR;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (i_out_ready) begin
          cnt_d   = cnt_inc(cnt_q);
          state_d = S_WAIT_SYM;
        end
      end
      S_ERR:   state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase

    if (i_abort) begin
      state_d      = S_IDLE;
      cnt_d        = 3'd0;
      wd_d         = '0;
      cfg_err_d    = 1'b0;
      hold_first_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= 3'd0;
      wd_q         <= '0;
      n_sc_q       <= 2'd0;
      cfg_err_q    <= 1'b0;
      hold_first_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wd_q         <= wd_d;
      n_sc_q       <= n_sc_d;
      cfg_err_q    <= cfg_err_d;
      hold_first_q <= hold_first_d;
    end
  end

  assign o_sym_ready   = (state_q == S_WAIT_SYM);
  assign o_sym_ack     = (state_q == S_SKIP) || ((state_q == S_HOLD) && hold_first_q);
  assign o_ifft_start  = (state_q == S_START);
  assign o_ifft_n_sc   = n_sc_q;
  assign o_out_valid   = (state_q == S_HOLD);
  assign o_out_sym_idx = (state_q == S_HOLD) ? cnt_q : 3'd0;
  assign o_out_last    = (state_q == S_HOLD) && (cnt_q == LAST_IDX);
  assign o_dmrs_skip   = (state_q == S_SKIP);
  assign o_cfg_err     = cfg_err_q;
  assign o_err_timeout = (state_q == S_ERR);
  assign o_busy        = (state_q != S_IDLE);

endmodule
